// File: rtl/alu_pkg.sv
// Shared ALU control definitions: operation codes, R-type function fields,
// control FSM states and the request decoder used by alu_seq_ctrl.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_MUL = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;

   localparam logic [5:0] FUNC_ADD   = 6'b100000;
   localparam logic [5:0] FUNC_SUB   = 6'b100010;
   localparam logic [5:0] FUNC_AND   = 6'b100100;
   localparam logic [5:0] FUNC_OR    = 6'b100101;
   localparam logic [5:0] FUNC_NOR   = 6'b100111;
   localparam logic [5:0] FUNC_SLT   = 6'b101010;
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

   typedef enum logic [2:0] {K_ALU, K_MFHI, K_MFLO, K_MULT, K_MULTU, K_ERR} kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [2:0] alu_op;
   } dec_t;

   function automatic dec_t alu_decode(input logic [1:0] op, input logic [5:0] func);
      dec_t d;
      d.kind   = K_ERR;
      d.alu_op = ALU_AND;
      case (op)
         OP_ADD: begin d.kind = K_ALU; d.alu_op = ALU_ADD; end
         OP_SUB: begin d.kind = K_ALU; d.alu_op = ALU_SUB; end
         OP_RTYPE: begin
            case (func)
               FUNC_ADD:   begin d.kind = K_ALU;   d.alu_op = ALU_ADD; end
               FUNC_SUB:   begin d.kind = K_ALU;   d.alu_op = ALU_SUB; end
               FUNC_AND:   begin d.kind = K_ALU;   d.alu_op = ALU_AND; end
               FUNC_OR:    begin d.kind = K_ALU;   d.alu_op = ALU_OR;  end
               FUNC_NOR:   begin d.kind = K_ALU;   d.alu_op = ALU_NOR; end
               FUNC_SLT:   begin d.kind = K_ALU;   d.alu_op = ALU_SLT; end
               FUNC_MFHI:  begin d.kind = K_MFHI;  d.alu_op = ALU_ADD; end
               FUNC_MFLO:  begin d.kind = K_MFLO;  d.alu_op = ALU_ADD; end
               FUNC_MULT:  begin d.kind = K_MULT;  d.alu_op = ALU_MUL; end
               FUNC_MULTU: begin d.kind = K_MULTU; d.alu_op = ALU_MUL; end
               default: ;
            endcase
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: WIDTH iterations on unsigned magnitudes,
// sign restored on the full 2*WIDTH product in the final iteration.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand_q, p_hi_q, p_lo_q;
   logic               neg_q, busy_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_mag, b_mag, p_hi_n, p_lo_n;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] raw;

   // The most negative operand negates to itself, which read unsigned is its magnitude.
   assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

   always_comb begin
      sum    = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
      p_hi_n = sum[WIDTH:1];
      p_lo_n = {sum[0], p_lo_q[WIDTH-1:1]};
      raw    = {p_hi_n, p_lo_n};
      prod_o = neg_q ? -raw : raw;
      done_o = busy_q && (cnt_q == '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (start_i) begin
         mcand_q <= a_mag;
         p_hi_q  <= '0;
         p_lo_q  <= b_mag;
         neg_q   <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         busy_q  <= 1'b1;
         cnt_q   <= CW'(WIDTH - 1);
      end else if (busy_q) begin
         p_hi_q <= p_hi_n;
         p_lo_q <= p_lo_n;
         if (cnt_q == '0) busy_q <= 1'b0;
         else             cnt_q  <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU control: decodes op/func, executes single-cycle ops in place and
// sequences mult/multu through alu_mul_seq into the hi/lo registers.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             valid_in,
   output logic             ready,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             valid_out,
   output logic             err
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d, alu_res;
   logic [2:0]         alu_op_q, alu_op_d;
   logic               valid_out_q, valid_out_d, err_q, err_d;
   logic               accept, mul_start, mul_signed, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   dec_t               dec;

   assign dec        = alu_decode(op, func);
   assign ready      = (state_q != ST_MUL);
   assign accept     = valid_in && ready;
   assign mul_signed = (dec.kind == K_MULT);

   always_comb begin
      alu_res = '0;
      case (dec.alu_op)
         ALU_ADD: alu_res = a + b;
         ALU_SUB: alu_res = a - b;
         ALU_AND: alu_res = a & b;
         ALU_OR:  alu_res = a | b;
         ALU_NOR: alu_res = ~(a | b);
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: ;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      alu_op_d    = alu_op_q;
      valid_out_d = 1'b0;
      err_d       = 1'b0;
      mul_start   = 1'b0;
      case (state_q)
         ST_MUL: begin
            if (mul_done) begin
               hi_d        = mul_prod[2*WIDTH-1:WIDTH];
               lo_d        = mul_prod[WIDTH-1:0];
               result_d    = mul_prod[WIDTH-1:0];
               alu_op_d    = ALU_MUL;
               valid_out_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         default: begin
            // DONE behaves as IDLE for acceptance, so back-to-back requests are not stalled.
            state_d = ST_IDLE;
            if (accept) begin
               valid_out_d = 1'b1;
               case (dec.kind)
                  K_ALU:  begin result_d = alu_res; alu_op_d = dec.alu_op; end
                  K_MFHI: begin result_d = hi_q;    alu_op_d = ALU_ADD;    end
                  K_MFLO: begin result_d = lo_q;    alu_op_d = ALU_ADD;    end
                  K_MULT, K_MULTU: begin
                     valid_out_d = 1'b0;
                     mul_start   = 1'b1;
                     state_d     = ST_MUL;
                  end
                  default: begin
                     result_d = '0;
                     alu_op_d = ALU_AND;
                     err_d    = 1'b1;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         alu_op_q    <= ALU_AND;
         valid_out_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         alu_op_q    <= alu_op_d;
         valid_out_q <= valid_out_d;
         err_q       <= err_d;
      end
   end

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mul_start),
      .signed_i (mul_signed),
      .a_i      (a),
      .b_i      (b),
      .done_o   (mul_done),
      .prod_o   (mul_prod)
   );

   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign alu_op    = alu_op_q;
   assign valid_out = valid_out_q;
   assign err       = err_q;

endmodule
